shift_decode_stage: RTL and testbench
=====================================

// Module: shift_decode_stage
// PURPOSE
//   Operand/decode stage directly upstream of the shifter. Accepts R-type
//   instructions with register operands, decodes SLL/SRL/SRA/SLLV/SRLV/SRAV,
//   and presents reg_data/shamt/shiftCtr/dest to the shifter through a
//   registered valid/ready interface. A 2-entry skid buffer allows full
//   throughput under downstream back-pressure. Non-shift words are consumed,
//   dropped and counted.
// PARAMETERS
//   CNT_W    16   width of the saturating drop counter
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   reset      in   1      synchronous, active-high reset
//   flush      in   1      discard all buffered and incoming work this cycle
//   in_valid   in   1      instr/rs_data/rt_data valid
//   in_ready   out  1      stage can accept (registered: = !skid_valid)
//   instr      in   32     instruction word
//   rs_data    in   32     GPR[rs] value
//   rt_data    in   32     GPR[rt] value
//   out_valid  out  1      shifter operands valid
//   out_ready  in   1      shifter/writeback consumes this cycle
//   reg_data   out  32     value to shift (always rt_data)
//   shamt      out  5      shift amount
//   shiftCtr   out  2      00 sll, 01 srl, 11 sra; 10 never driven
//   dest       out  5      destination register rd = instr[15:11]
//   drop_cnt   out  CNT_W  count of dropped words, saturates at all-ones
// BEHAVIOUR
//   Decode (opcode instr[31:26]==0 required), funct = instr[5:0]:
//     000000 sll: shamt=instr[10:6], shiftCtr=00
//     000010 srl: shamt=instr[10:6], shiftCtr=01
//     000011 sra: shamt=instr[10:6], shiftCtr=11
//     000100 sllv / 000110 srlv / 000111 srav: shamt=rs_data[4:0]
//       (upper rs bits ignored), shiftCtr 00/01/11 respectively
//   Drop: any other opcode/funct, and instr==32'h0 (NOP), are accepted when
//     in_ready and discarded; drop_cnt += 1 unless saturated.
//   Handshake: accept when in_valid & in_ready; transfer out when
//     out_valid & out_ready. Outputs are fully registered, so an accepted
//     shift first appears on out_* the next cycle (latency 1). out_* remain
//     stable while out_valid & !out_ready.
//   Buffer states (main reg M, skid reg S):
//     EMPTY: accepted shift -> M, go ONE.
//     ONE:   transfer & accept -> M<=new, stay ONE; transfer only -> EMPTY;
//            accept only -> S<=new, go FULL; neither -> hold.
//     FULL:  in_ready=0; transfer -> M<=S, go ONE; else hold.
//     Dropped words never change the state.
//   flush: next state EMPTY, out_valid=0 next cycle, in_ready=1 next cycle;
//     input presented in the flush cycle is neither buffered nor counted.
//     flush has priority over accept/transfer; reset has priority over flush.
//   Reset: out_valid=0, in_ready=1, reg_data=0, shamt=0, shiftCtr=00,
//     dest=0, drop_cnt=0, state EMPTY. Reset mid-transfer loses all work.
//   No combinational path from out_ready to in_ready.
// TESTING
//   1 Reset held 2 cycles -> out_valid=0, in_ready=1, drop_cnt=0, outs 0.
//   2 sra $3,$2,4 (32'h00021903) rt=32'hF000_0000, out_ready=1 -> next
//     cycle out_valid=1, reg_data=F000_0000, shamt=4, shiftCtr=11, dest=3.
//   3 srlv rd=5 with rs=32'h0000_0123, rt=32'h8000_0001 -> shamt=3 (bits
//     [4:0] of rs), shiftCtr=01, dest=5.
//   4 out_ready=0, issue 3 back-to-back shifts -> 2 accepted, in_ready=0
//     after 2nd; release out_ready -> outputs in issue order, none lost/dup.
//   5 NOP 32'h0 and addu word -> out_valid stays 0, drop_cnt=2; preload
//     counter to all-ones -> stays all-ones.
//   6 FULL state, assert flush with in_valid=1 -> next cycle out_valid=0,
//     in_ready=1, flushed input absent at output, drop_cnt unchanged.

Source files
------------

// File: rtl/shift_decode_stage.sv
// shift_decode_stage: decodes R-type shifts and feeds the shifter through a 2-entry skid buffer.
// Rev 1.0
`default_nettype none

module shift_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      reg_data,
  output logic [4:0]       shamt,
  output logic [1:0]       shiftCtr,
  output logic [4:0]       dest,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [31:0] m_data,  s_data;
  logic [4:0]  m_shamt, s_shamt;
  logic [1:0]  m_ctr,   s_ctr;
  logic [4:0]  m_dest,  s_dest;

  logic       dec_shift;
  logic [4:0] dec_shamt;
  logic [1:0] dec_ctr;
  logic       accept, take, drop, xfer;
  logic       load_m, load_s, promote;

  // Only the low five rs bits matter, and rs/rt fields arrive pre-read.
  logic unused_bits;
  assign unused_bits = ^{instr[25:16], rs_data[31:5]};

  always_comb begin
    dec_shift = 1'b0;
    dec_shamt = instr[10:6];
    dec_ctr   = 2'b00;
    if (instr[31:26] == 6'd0 && instr != 32'd0) begin
      case (instr[5:0])
        6'b000000: dec_shift = 1'b1;
        6'b000010: begin dec_shift = 1'b1; dec_ctr = 2'b01; end
        6'b000011: begin dec_shift = 1'b1; dec_ctr = 2'b11; end
        6'b000100: begin dec_shift = 1'b1; dec_shamt = rs_data[4:0]; end
        6'b000110: begin dec_shift = 1'b1; dec_shamt = rs_data[4:0]; dec_ctr = 2'b01; end
        6'b000111: begin dec_shift = 1'b1; dec_shamt = rs_data[4:0]; dec_ctr = 2'b11; end
        default:   dec_shift = 1'b0;
      endcase
    end
  end

  // Both handshake flags derive from the state register only.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);

  assign accept = in_valid & in_ready & ~flush;
  assign take   = accept & dec_shift;
  assign drop   = accept & ~dec_shift;
  assign xfer   = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    promote   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (take) begin
            load_m    = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (xfer && take) begin
            load_m = 1'b1;
          end else if (xfer) begin
            state_nxt = EMPTY;
          end else if (take) begin
            load_s    = 1'b1;
            state_nxt = FULL;
          end
        end
        FULL: begin
          if (xfer) begin
            promote   = 1'b1;
            state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_data  <= 32'd0;
      m_shamt <= 5'd0;
      m_ctr   <= 2'b00;
      m_dest  <= 5'd0;
      s_data  <= 32'd0;
      s_shamt <= 5'd0;
      s_ctr   <= 2'b00;
      s_dest  <= 5'd0;
    end else begin
      if (load_m) begin
        m_data  <= rt_data;
        m_shamt <= dec_shamt;
        m_ctr   <= dec_ctr;
        m_dest  <= instr[15:11];
      end else if (promote) begin
        m_data  <= s_data;
        m_shamt <= s_shamt;
        m_ctr   <= s_ctr;
        m_dest  <= s_dest;
      end
      if (load_s) begin
        s_data  <= rt_data;
        s_shamt <= dec_shamt;
        s_ctr   <= dec_ctr;
        s_dest  <= instr[15:11];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != {CNT_W{1'b1}}) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign reg_data = m_data;
  assign shamt    = m_shamt;
  assign shiftCtr = m_ctr;
  assign dest     = m_dest;

endmodule

`default_nettype wire

// File: tb/tb_shift_decode_stage.sv
// tb_shift_decode_stage: directed and random checks of shift_decode_stage against a queue model.
`default_nettype none

module tb_shift_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;

  logic        in_ready, out_valid;
  logic [31:0] reg_data;
  logic [4:0]  shamt, dest;
  logic [1:0]  shiftCtr;
  logic [15:0] drop_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_reg_data;
  logic [4:0]  s_shamt, s_dest;
  logic [1:0]  s_shiftCtr;
  logic [2:0]  s_drop_cnt;

  shift_decode_stage #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_data(reg_data), .shamt(shamt), .shiftCtr(shiftCtr), .dest(dest),
    .drop_cnt(drop_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a few cycles.
  shift_decode_stage #(.CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .reg_data(s_reg_data), .shamt(s_shamt), .shiftCtr(s_shiftCtr), .dest(s_dest),
    .drop_cnt(s_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  ctr;
    logic [4:0]  dest;
  } exp_t;

  exp_t q[$];
  int   cnt = 0;
  int   cnt_s = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  function automatic bit ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                    input logic [31:0] rt, output exp_t e);
    logic [1:0] op;
    e.data  = rt;
    e.dest  = ins[15:11];
    e.shamt = ins[2] ? rs[4:0] : ins[10:6];
    op      = ins[1:0];
    case (op)
      2'b00:   e.ctr = 2'b00;
      2'b10:   e.ctr = 2'b01;
      default: e.ctr = 2'b11;
    endcase
    return (ins != 32'd0) && (ins[31:26] == 6'd0) && (ins[5:3] == 3'd0) && (op != 2'b01);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("drop_cnt", {16'd0, drop_cnt}, cnt);
    chk("sat_drop_cnt", {29'd0, s_drop_cnt}, cnt_s);
    if (q.size() > 0) begin
      chk("reg_data", reg_data, q[0].data);
      chk("shamt", {27'd0, shamt}, {27'd0, q[0].shamt});
      chk("shiftCtr", {30'd0, shiftCtr}, {30'd0, q[0].ctr});
      chk("dest", {27'd0, dest}, {27'd0, q[0].dest});
    end
  endtask

  task automatic step();
    exp_t e;
    bit   ok, acc, xf;
    ok  = ref_decode(instr, rs_data, rt_data, e);
    acc = in_valid && (q.size() < 2) && !flush;
    xf  = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (reset) begin
      q.delete();
      cnt   = 0;
      cnt_s = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (xf) void'(q.pop_front());
      if (acc && ok) q.push_back(e);
      if (acc && !ok) begin
        if (cnt != 65535) cnt++;
        if (cnt_s != 7) cnt_s++;
      end
    end
    #1;
    check_state();
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sa,
                                       input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] rand_shift();
    logic [5:0] ftab [6];
    ftab = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111};
    return mk_r(5'($urandom), 5'($urandom), 5'($urandom_range(1, 31)), 5'($urandom),
                ftab[$urandom_range(0, 5)]);
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    logic [31:0] w;
    k = $urandom_range(0, 9);
    w = $urandom();
    if (k < 7) return rand_shift();
    else if (k == 7) return 32'd0;
    else if (k == 8) return mk_r(5'($urandom), 5'($urandom), 5'($urandom), 5'd0, 6'h21);
    else return w | 32'h0400_0000;
  endfunction

  int saved;

  initial begin
    // 1: reset held two cycles
    reset = 1'b1;
    step();
    step();
    chk("rst_reg_data", reg_data, 32'd0);
    chk("rst_shamt", {27'd0, shamt}, 32'd0);
    chk("rst_shiftCtr", {30'd0, shiftCtr}, 32'd0);
    chk("rst_dest", {27'd0, dest}, 32'd0);
    reset = 1'b0;

    // 2: sra $3,$2,4
    instr = 32'h0002_1903; rt_data = 32'hF000_0000; rs_data = 32'h1234_5678;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("sra_valid", {31'd0, out_valid}, 32'd1);
    chk("sra_data", reg_data, 32'hF000_0000);
    chk("sra_shamt", {27'd0, shamt}, 32'd4);
    chk("sra_ctr", {30'd0, shiftCtr}, 32'd3);
    chk("sra_dest", {27'd0, dest}, 32'd3);

    // 3: srlv rd=5 using rs[4:0]
    instr = mk_r(5'd1, 5'd2, 5'd5, 5'd0, 6'b000110);
    rs_data = 32'h0000_0123; rt_data = 32'h8000_0001;
    step();
    chk("srlv_shamt", {27'd0, shamt}, 32'd3);
    chk("srlv_ctr", {30'd0, shiftCtr}, 32'd1);
    chk("srlv_dest", {27'd0, dest}, 32'd5);
    chk("srlv_data", reg_data, 32'h8000_0001);
    in_valid = 1'b0;
    step();

    // 4: back-pressure with three back-to-back shifts
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr = rand_shift(); rs_data = $urandom(); rt_data = $urandom();
      step();
      if (i == 1) chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // 5: dropped words and saturation
    saved = cnt;
    in_valid = 1'b1;
    instr = 32'd0; step();
    instr = mk_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21); step();
    in_valid = 1'b0; step();
    chk("drop_valid", {31'd0, out_valid}, 32'd0);
    chk("drop_two", {16'd0, drop_cnt}, saved + 2);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) step();
    in_valid = 1'b0;
    chk("sat_all_ones", {29'd0, s_drop_cnt}, 32'd7);
    step();

    // 6: flush from FULL with a valid input present
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instr = rand_shift(); rt_data = $urandom(); rs_data = $urandom();
      step();
    end
    saved = cnt;
    flush = 1'b1; instr = rand_shift();
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_cnt", {16'd0, drop_cnt}, saved);
    step();
    chk("flush_absent", {31'd0, out_valid}, 32'd0);

    // Random traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      instr     = rand_instr();
      rs_data   = $urandom();
      rt_data   = $urandom();
      step();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
